// File: rtl/glyph_pkg.sv
// Shared glyph geometry and writer FSM state encodings.
// Used by the glyph RAM writer and the sprite reader.
package glyph_pkg;

  localparam int GLYPH_W   = 24;
  localparam int GLYPH_H   = 24;
  localparam int GLYPH_NUM = 10;

  typedef logic [1:0] glyph_state_t;

  localparam glyph_state_t ST_IDLE   = 2'd0;
  localparam glyph_state_t ST_RECV   = 2'd1;
  localparam glyph_state_t ST_UNPACK = 2'd2;
  localparam glyph_state_t ST_DONE   = 2'd3;

endpackage

// File: rtl/glyph_ram_writer_byte_serializer.sv
// Holds one packed pixel byte and presents it MSB-first, one bit per shift.
// last_out flags the eighth bit so the owner knows when to fetch the next byte.
module byte_serializer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_in,
  input  logic [7:0] byte_in,
  input  logic       shift_in,
  output logic       bit_out,
  output logic       last_out
);

  logic [7:0] shreg_q, shreg_d;
  logic [2:0] cnt_q, cnt_d;

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (load_in) begin
      shreg_d = byte_in;
      cnt_d   = 3'd0;
    end else if (shift_in) begin
      shreg_d = {shreg_q[6:0], 1'b0};
      cnt_d   = cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // Shifting stops on the last bit, so bit_out holds the final pixel afterwards.
  assign bit_out  = shreg_q[7];
  assign last_out = (cnt_q == 3'd7);

endmodule

// File: rtl/glyph_ram_writer.sv
// Loads one glyph into a 1-bit glyph RAM from a stream of packed pixel bytes,
// writing pixel (col,row) of slot g at g*WIDTH*HEIGHT + row*WIDTH + col.
module glyph_ram_writer
  import glyph_pkg::*;
#(
  parameter int WIDTH    = GLYPH_W,
  parameter int HEIGHT   = GLYPH_H,
  parameter int NUM_IMGS = GLYPH_NUM,
  parameter int ADDR_W   = $clog2(WIDTH * HEIGHT * NUM_IMGS)
) (
  input  logic              pixel_clk_in,
  input  logic              rst_n_in,
  input  logic              start_in,
  input  logic [3:0]        glyph_in,
  input  logic [7:0]        data_in,
  input  logic              data_valid_in,
  output logic              data_ready_out,
  output logic              wr_en_out,
  output logic [ADDR_W-1:0] wr_addr_out,
  output logic              wr_data_out,
  output logic              busy_out,
  output logic              done_out,
  output logic              error_out
);

  localparam int PIX   = WIDTH * HEIGHT;
  localparam int CNT_W = $clog2(PIX + 1);
  localparam logic [CNT_W-1:0] PIX_CNT_END = CNT_W'(PIX);

  if (PIX % 8 != 0) begin : g_bad_geometry
    $error("glyph_ram_writer: WIDTH*HEIGHT must be a multiple of 8");
  end

  glyph_state_t      state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              error_q, error_d;

  logic start_ok;
  logic transfer;
  logic ser_bit;
  logic ser_last;
  logic ser_shift;

  assign start_ok  = (int'(glyph_in) < NUM_IMGS);
  assign transfer  = data_ready_out && data_valid_in;
  assign ser_shift = (state_q == ST_UNPACK) && !ser_last;

  byte_serializer u_ser (
    .clk      (pixel_clk_in),
    .rst_n    (rst_n_in),
    .load_in  (transfer),
    .byte_in  (data_in),
    .shift_in (ser_shift),
    .bit_out  (ser_bit),
    .last_out (ser_last)
  );

  // pix_cnt_q is the index of the next pixel to present; the write address is
  // registered one step ahead so it appears in the same cycle as wr_en_out.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    pix_cnt_d = pix_cnt_q;
    wr_addr_d = wr_addr_q;
    error_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          if (start_ok) begin
            state_d   = ST_RECV;
            base_d    = ADDR_W'(int'(glyph_in) * PIX);
            pix_cnt_d = '0;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      ST_RECV: begin
        if (transfer) begin
          state_d   = ST_UNPACK;
          wr_addr_d = base_q + ADDR_W'(pix_cnt_q);
          pix_cnt_d = pix_cnt_q + 1'b1;
        end
      end
      ST_UNPACK: begin
        if (!ser_last) begin
          wr_addr_d = base_q + ADDR_W'(pix_cnt_q);
          pix_cnt_d = pix_cnt_q + 1'b1;
        end else if (pix_cnt_q == PIX_CNT_END) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RECV;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= ST_IDLE;
      base_q    <= '0;
      pix_cnt_q <= '0;
      wr_addr_q <= '0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      pix_cnt_q <= pix_cnt_d;
      wr_addr_q <= wr_addr_d;
      error_q   <= error_d;
    end
  end

  assign data_ready_out = (state_q == ST_RECV);
  assign wr_en_out      = (state_q == ST_UNPACK);
  assign wr_addr_out    = wr_addr_q;
  assign wr_data_out    = ser_bit;
  assign busy_out       = (state_q == ST_RECV) || (state_q == ST_UNPACK);
  assign done_out       = (state_q == ST_DONE);
  assign error_out      = error_q;

endmodule

// File: tb/tb_glyph_ram_writer.sv
// Randomized scoreboard bench for glyph_ram_writer: stimulus pushes expected
// pixel writes, an independent monitor pops and compares them.
module tb_glyph_ram_writer;

  localparam int W     = 24;
  localparam int H     = 24;
  localparam int N     = 10;
  localparam int PIX   = W * H;
  localparam int BYTES = PIX / 8;
  localparam int TOTAL = PIX * N;
  localparam int AW    = $clog2(TOTAL);

  logic          clk;
  logic          rst_n;
  logic          start_in;
  logic [3:0]    glyph_in;
  logic [7:0]    data_in;
  logic          data_valid_in;
  logic          data_ready_out;
  logic          wr_en_out;
  logic [AW-1:0] wr_addr_out;
  logic          wr_data_out;
  logic          busy_out;
  logic          done_out;
  logic          error_out;

  typedef struct {
    logic [AW-1:0] addr;
    logic          bit_v;
    bit            last;
  } wr_t;

  wr_t  exp_q[$];
  wr_t  mon_e;
  logic exp_mem [0:TOTAL-1];
  logic act_mem [0:TOTAL-1];
  int   compared   = 0;
  int   mismatched = 0;
  bit   err_allow  = 0;
  int   mon_wr_count = 0;
  bit   mon_done_due = 0;

  glyph_ram_writer #(
    .WIDTH(W), .HEIGHT(H), .NUM_IMGS(N), .ADDR_W(AW)
  ) dut (
    .pixel_clk_in   (clk),
    .rst_n_in       (rst_n),
    .start_in       (start_in),
    .glyph_in       (glyph_in),
    .data_in        (data_in),
    .data_valid_in  (data_valid_in),
    .data_ready_out (data_ready_out),
    .wr_en_out      (wr_en_out),
    .wr_addr_out    (wr_addr_out),
    .wr_data_out    (wr_data_out),
    .busy_out       (busy_out),
    .done_out       (done_out),
    .error_out      (error_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: actual %0h required %0h", name, actual, expected);
    end
  endtask

  // Monitor: pops one expected write per observed strobe; done must follow the last one.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_wr_count = 0;
        mon_done_due = 0;
      end else begin
        if (mon_done_due) begin
          checkOutput("done_pulse", 32'(done_out), 32'd1);
          checkOutput("glyph_write_count", mon_wr_count, PIX);
          mon_wr_count = 0;
          mon_done_due = 0;
        end else if (done_out) begin
          checkOutput("unexpected_done", 32'(done_out), 32'd0);
        end
        if (error_out && !err_allow)
          checkOutput("unexpected_error", 32'(error_out), 32'd0);
        if (wr_en_out) begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_write", 32'(wr_en_out), 32'd0);
          end else begin
            mon_e = exp_q.pop_front();
            checkOutput("wr_addr", 32'(wr_addr_out), 32'(mon_e.addr));
            checkOutput("wr_data", 32'(wr_data_out), 32'(mon_e.bit_v));
            if (int'(wr_addr_out) < TOTAL) act_mem[wr_addr_out] = wr_data_out;
            mon_wr_count++;
            if (mon_e.last) mon_done_due = 1;
          end
        end
      end
    end
  end

  task automatic startGlyph(input logic [3:0] g);
    @(negedge clk);
    start_in = 1'b1;
    glyph_in = g;
    @(negedge clk);
    start_in = 1'b0;
  endtask

  // Offers one byte and, once it transfers, records the eight pixels it must produce.
  task automatic applyStimulus(input int slot, input int idx, input logic [7:0] b,
                               input int gap, output int waited, output bit ok);
    wr_t e;
    int  pix;
    repeat (gap) begin
      @(negedge clk);
      data_valid_in = 1'b0;
    end
    @(negedge clk);
    data_in       = b;
    data_valid_in = 1'b1;
    waited = 0;
    while (!data_ready_out && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    ok = data_ready_out;
    if (!ok) begin
      checkOutput("ready_timeout", 32'(data_ready_out), 32'd1);
    end else begin
      for (int i = 0; i < 8; i++) begin
        pix     = idx * 8 + i;
        e.addr  = AW'(slot * PIX + pix);
        e.bit_v = b[7-i];
        e.last  = (pix == PIX - 1);
        exp_q.push_back(e);
        exp_mem[slot * PIX + pix] = b[7-i];
      end
      @(posedge clk);
    end
  endtask

  task automatic loadGlyph(input int slot, input int gap_max, input int fixed_byte,
                           input int stop_after, input int interrupt_at, input bit check_period);
    int         waited;
    int         gap;
    int         n;
    bit         ok;
    logic [7:0] b;
    startGlyph(4'(slot));
    checkOutput("busy_after_start", 32'(busy_out), 32'd1);
    for (int idx = 0; idx < BYTES; idx++) begin
      if (idx == stop_after) return;
      gap = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
      b   = (fixed_byte >= 0) ? 8'(fixed_byte) : 8'($urandom);
      applyStimulus(slot, idx, b, gap, waited, ok);
      if (!ok) return;
      if (check_period && idx > 0 && gap == 0)
        checkOutput("byte_period", waited, 8);
      if (idx == interrupt_at) begin
        @(negedge clk);
        start_in = 1'b1;
        glyph_in = 4'd5;
        @(negedge clk);
        start_in = 1'b0;
        checkOutput("busy_during_load", 32'(busy_out), 32'd1);
      end
    end
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain", exp_q.size(), 0);
    data_valid_in = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("busy_after_done", 32'(busy_out), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: actual timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] exp_row;
    logic [31:0] act_row;
    logic [7:0]  got_byte;
    for (int i = 0; i < TOTAL; i++) begin
      exp_mem[i] = 1'b0;
      act_mem[i] = 1'b0;
    end
    rst_n = 1'b0;
    start_in = 1'b0;
    glyph_in = 4'd0;
    data_in = 8'd0;
    data_valid_in = 1'b0;
    #1;
    checkOutput("rst_ready", 32'(data_ready_out), 32'd0);
    checkOutput("rst_wr_en", 32'(wr_en_out), 32'd0);
    checkOutput("rst_wr_addr", 32'(wr_addr_out), 32'd0);
    checkOutput("rst_wr_data", 32'(wr_data_out), 32'd0);
    checkOutput("rst_busy", 32'(busy_out), 32'd0);
    checkOutput("rst_done", 32'(done_out), 32'd0);
    checkOutput("rst_error", 32'(error_out), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] slot 3, constant 0xA5, valid held high");
    loadGlyph(3, 0, 8'hA5, -1, -1, 1'b1);
    for (int i = 0; i < 8; i++) got_byte[7-i] = act_mem[3 * PIX + i];
    checkOutput("slot3_first_byte", 32'(got_byte), 32'hA5);
    checkOutput("slot3_last_bit", 32'(act_mem[3 * PIX + PIX - 1]), 32'd1);

    $display("[TB] out-of-range slot 12");
    @(negedge clk);
    err_allow = 1'b1;
    start_in = 1'b1;
    glyph_in = 4'd12;
    @(negedge clk);
    start_in = 1'b0;
    checkOutput("error_pulse", 32'(error_out), 32'd1);
    checkOutput("error_busy", 32'(busy_out), 32'd0);
    checkOutput("error_wr_en", 32'(wr_en_out), 32'd0);
    @(negedge clk);
    checkOutput("error_clears", 32'(error_out), 32'd0);
    checkOutput("error_stays_idle", 32'(data_ready_out), 32'd0);
    err_allow = 1'b0;

    $display("[TB] slot 0, random bytes with valid gaps");
    loadGlyph(0, 3, -1, -1, -1, 1'b0);

    $display("[TB] slot 2 with a stray start mid-load");
    loadGlyph(2, 1, -1, -1, 30, 1'b0);

    $display("[TB] slot 7 aborted by reset after byte 10");
    loadGlyph(7, 0, -1, 10, -1, 1'b0);
    #2;
    rst_n = 1'b0;
    data_valid_in = 1'b0;
    exp_q.delete();
    #1;
    checkOutput("abort_wr_en", 32'(wr_en_out), 32'd0);
    checkOutput("abort_busy", 32'(busy_out), 32'd0);
    checkOutput("abort_wr_addr", 32'(wr_addr_out), 32'd0);
    checkOutput("abort_wr_data", 32'(wr_data_out), 32'd0);
    checkOutput("abort_ready", 32'(data_ready_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    loadGlyph(7, 0, -1, -1, -1, 1'b0);

    $display("[TB] slot 9 full load and bitmap readback");
    loadGlyph(9, 2, -1, -1, -1, 1'b0);
    for (int r = 0; r < H; r++) begin
      exp_row = '0;
      act_row = '0;
      for (int c = 0; c < W; c++) begin
        exp_row[W-1-c] = exp_mem[9 * PIX + r * W + c];
        act_row[W-1-c] = act_mem[9 * PIX + r * W + c];
      end
      checkOutput("slot9_row", act_row, exp_row);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
